// File: rtl/core_exec_pkg.sv
// Shared definitions for the core execution controller: opcode encoding,
// controller state encoding and a small state classification helper.
package core_exec_pkg;

    localparam int OP_WIDTH = 3;

    // Command opcodes; encodings 6 and 7 are illegal.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP        = 3'd0,
        OP_RESET_CORE = 3'd1,
        OP_STOP       = 3'd2,
        OP_RUN        = 3'd3,
        OP_STEP       = 3'd4,
        OP_RUN_UNTIL  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_RESETTING = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_STEPPING  = 3'd3,
        ST_UNTIL     = 3'd4
    } state_e;

    // True for the states in which the core is being clocked on behalf of a command.
    function automatic logic is_active(input state_e s);
        return (s == ST_RUNNING) || (s == ST_STEPPING) || (s == ST_UNTIL);
    endfunction

endpackage

// File: rtl/exec_down_counter.sv
// Loadable down-counter with zero flag. Holds the number of enabled cycles
// still to come after the current one, for both the core reset pulse and STEP.
module exec_down_counter #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Count register: load has priority over decrement; saturates at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/core_exec_ctrl.sv
// Command-driven execution controller for the core under test. Drives the
// core clock enable and core reset from UART-decoded commands: reset pulse,
// stop, free-run, step N cycles and run until a breakpoint address is hit.
// Optional feature macro: CORE_CYCLE_COUNTER_EN (enables cycle_count register).
module core_exec_ctrl
    import core_exec_pkg::*;
#(
    parameter int ARG_WIDTH        = 32,
    parameter int RESET_CLK_CYCLES = 20,
    parameter int CYCLE_BITS       = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [ARG_WIDTH-1:0]  cmd_arg,
    input  logic                  core_mem_valid,
    input  logic [ARG_WIDTH-1:0]  core_address,
    output logic                  clk_core_en,
    output logic                  reset_core,
    output logic                  busy,
    output logic                  done,
    output logic                  bp_hit,
    output logic                  cmd_err,
    output logic [CYCLE_BITS-1:0] cycle_count
);

    // The counter holds "remaining cycles after this one", so the reset pulse
    // and a STEP of N both load their length minus one.
    localparam logic [ARG_WIDTH-1:0] RESET_LOAD = ARG_WIDTH'(RESET_CLK_CYCLES - 1);

    state_e               state_q, state_d;
    logic [ARG_WIDTH-1:0] bp_addr_q;
    logic                 bp_load;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [ARG_WIDTH-1:0] cnt_load_val;
    logic                 done_d, bp_hit_d, err_d;
    logic                 accept, bp_match;

    assign accept   = cmd_valid && cmd_ready;
    assign bp_match = clk_core_en && core_mem_valid && (core_address == bp_addr_q);

    exec_down_counter #(
        .WIDTH     (ARG_WIDTH),
        .RESET_VAL (RESET_LOAD)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state logic: state progression first, then command handling, so a
    // STOP or RESET_CORE can override a completion in the same cycle.
    // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = RESET_LOAD;
        cnt_dec      = 1'b0;
        bp_load      = 1'b0;
        done_d       = 1'b0;
        bp_hit_d     = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_RESETTING: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_NOP: ;
                        OP_RESET_CORE: begin
                            state_d  = ST_RESETTING;
                            cnt_load = 1'b1;
                        end
                        OP_STOP: done_d = 1'b1;
                        OP_RUN:  state_d = ST_RUNNING;
                        OP_STEP: begin
                            if (cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d      = ST_STEPPING;
                                cnt_load     = 1'b1;
                                cnt_load_val = cmd_arg - ARG_WIDTH'(1);
                            end
                        end
                        OP_RUN_UNTIL: begin
                            state_d = ST_UNTIL;
                            bp_load = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_RUNNING: ;
            ST_STEPPING: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_UNTIL: begin
                if (bp_match) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    bp_hit_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_RESETTING;
                cnt_load = 1'b1;
            end
        endcase

        // Commands arriving while the core is being clocked.
        if (is_active(state_q) && accept) begin
            case (op_e'(cmd_op))
                OP_NOP: ;
                OP_RESET_CORE: begin
                    state_d      = ST_RESETTING;
                    cnt_load     = 1'b1;
                    cnt_load_val = RESET_LOAD;
                    cnt_dec      = 1'b0;
                    done_d       = 1'b0;
                    bp_hit_d     = 1'b0;
                end
                OP_STOP: begin
                    // A breakpoint or final step in the same cycle keeps its
                    // own done/bp_hit; this only merges into a single done.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESETTING;
            reset_core  <= 1'b1;
            clk_core_en <= 1'b1;
            busy        <= 1'b1;
            cmd_ready   <= 1'b0;
            done        <= 1'b0;
            bp_hit      <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            reset_core  <= (state_d == ST_RESETTING);
            clk_core_en <= (state_d == ST_RESETTING) || is_active(state_d);
            busy        <= (state_d != ST_IDLE);
            cmd_ready   <= (state_d != ST_RESETTING);
            done        <= done_d;
            bp_hit      <= bp_hit_d;
            cmd_err     <= err_d;
        end
    end

    // Breakpoint address latch, written on RUN_UNTIL acceptance.
    // NOTE: pure datapath register with no reset; it is only read in UNTIL, which is entered on the same edge that loads it.
    always_ff @(posedge clk) begin
        if (bp_load) begin
            bp_addr_q <= cmd_arg;
        end
    end

`ifdef CORE_CYCLE_COUNTER_EN
    logic [CYCLE_BITS-1:0] cycle_q;

    // Executed-cycle counter: counts enabled core cycles, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else if (clk_core_en) begin
            cycle_q <= cycle_q + CYCLE_BITS'(1);
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Self-checking bench for core_exec_ctrl. Completion pulses are checked
// against a scoreboard queue of {done, bp_hit, cmd_err} expectations.
module tb_core_exec_ctrl;
    import core_exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = '0;
    logic        core_mem_valid = 1'b0;
    logic [31:0] core_address = '0;
    logic        clk_core_en, reset_core, busy, done, bp_hit, cmd_err;
    logic [63:0] cycle_count;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    logic [2:0]  sb[$];
    logic [2:0]  mon_exp;
    logic [63:0] model_cycles = '0;

    core_exec_ctrl #(
        .ARG_WIDTH        (32),
        .RESET_CLK_CYCLES (20),
        .CYCLE_BITS       (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .core_mem_valid (core_mem_valid),
        .core_address   (core_address),
        .clk_core_en    (clk_core_en),
        .reset_core     (reset_core),
        .busy           (busy),
        .done           (done),
        .bp_hit         (bp_hit),
        .cmd_err        (cmd_err),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference count of enabled core cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_cycles <= '0;
        else if (clk_core_en === 1'b1) model_cycles <= model_cycles + 64'd1;
    end

    function automatic logic [63:0] exp_cycles();
`ifdef CORE_CYCLE_COUNTER_EN
        return model_cycles;
`else
        return 64'd0;
`endif
    endfunction

    // Scoreboard monitor: every completion/error pulse must match the next expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (done | bp_hit | cmd_err) !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'({done, bp_hit, cmd_err}), 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("pulse", 64'({done, bp_hit, cmd_err}), 64'(mon_exp));
            end
        end
    end

    // Offer one command at a negedge; the handshake happens on the following posedge.
    task automatic send(input logic [2:0] op, input logic [31:0] arg, input string tag);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
    endtask

    task automatic drained(input string tag);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Release reset and measure the core reset pulse; returns at the first IDLE negedge.
    task automatic release_and_measure(input string tag);
        int  n;
        logic rdy_seen, en_low;
        n = 0; rdy_seen = 1'b0; en_low = 1'b0;
        reset = 1'b1;
        sb.push_back(3'b100);
        while (reset_core === 1'b1 && n < 100) begin
            n++;
            if (cmd_ready !== 1'b0) rdy_seen = 1'b1;
            if (clk_core_en !== 1'b1) en_low = 1'b1;
            @(negedge clk);
        end
        check({tag, "_len"}, 64'(n), 64'd20);
        check({tag, "_ready_low"}, 64'(rdy_seen), 64'd0);
        check({tag, "_en_high"}, 64'(en_low), 64'd0);
        check({tag, "_idle"}, 64'({reset_core, busy, cmd_ready, clk_core_en}), 64'b0010);
        drained({tag, "_done"});
    endtask

    initial begin
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({reset_core, clk_core_en, busy, cmd_ready, done, bp_hit, cmd_err}),
              64'b1110000);
        check("rst_cycles", cycle_count, 64'd0);

        @(negedge clk);
        release_and_measure("boot");
        check("boot_cycles", cycle_count, exp_cycles());

        // STEP 5.
        @(negedge clk);
        sb.push_back(3'b100);
        send(OP_STEP, 32'd5, "step5");
        n = 0;
        while (clk_core_en === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("step5_len", 64'(n), 64'd5);
        check("step5_busy", 64'(busy), 64'd0);
        drained("step5_done");
        check("step5_cycles", cycle_count, exp_cycles());

        // RUN_UNTIL 0x40 with a linear address walk.
        @(negedge clk);
        sb.push_back(3'b110);
        send(OP_RUN_UNTIL, 32'h40, "until");
        for (int i = 0; i <= 16; i++) begin
            core_mem_valid = 1'b1;
            core_address   = 32'(i * 4);
            check("until_en", 64'(clk_core_en), 64'd1);
            @(negedge clk);
        end
        core_mem_valid = 1'b0;
        core_address   = '0;
        check("until_stop_en", 64'({clk_core_en, busy}), 64'b00);
        drained("until_done");

        // RUN, rejected STEP while running, STOP after 100 cycles.
        @(negedge clk);
        send(OP_RUN, 32'd0, "run");
        repeat (49) @(negedge clk);
        sb.push_back(3'b001);
        send(OP_STEP, 32'd3, "run_step");
        check("run_step_state", 64'({clk_core_en, busy}), 64'b11);
        drained("run_step_err");
        repeat (49) @(negedge clk);
        check("run_still_en", 64'(clk_core_en), 64'd1);
        sb.push_back(3'b100);
        send(OP_STOP, 32'd0, "run_stop");
        check("run_stop_en", 64'({clk_core_en, busy}), 64'b00);
        drained("run_stop_done");
        check("run_cycles", cycle_count, exp_cycles());

        // STEP 0 and an illegal opcode.
        @(negedge clk);
        sb.push_back(3'b100);
        send(OP_STEP, 32'd0, "step0");
        check("step0_en", 64'(clk_core_en), 64'd0);
        drained("step0_done");
        @(negedge clk);
        sb.push_back(3'b001);
        send(3'd7, 32'd0, "illegal");
        check("illegal_state", 64'({clk_core_en, busy}), 64'b00);
        drained("illegal_err");
        check("step0_cycles", cycle_count, exp_cycles());

        // Breakpoint and STOP in the same cycle: single done with bp_hit.
        @(negedge clk);
        send(OP_RUN_UNTIL, 32'h100, "bpstop_until");
        repeat (3) @(negedge clk);
        core_mem_valid = 1'b1;
        core_address   = 32'h100;
        sb.push_back(3'b110);
        send(OP_STOP, 32'd0, "bpstop_stop");
        core_mem_valid = 1'b0;
        core_address   = '0;
        check("bpstop_en", 64'({clk_core_en, busy}), 64'b00);
        drained("bpstop_done");

        // STOP on the final STEP cycle: one done, no error.
        @(negedge clk);
        sb.push_back(3'b100);
        send(OP_STEP, 32'd3, "laststop_step");
        repeat (2) @(negedge clk);
        check("laststop_en", 64'(clk_core_en), 64'd1);
        send(OP_STOP, 32'd0, "laststop_stop");
        check("laststop_idle", 64'({clk_core_en, busy}), 64'b00);
        drained("laststop_done");
        repeat (3) @(negedge clk);

        // Reset asserted in the middle of STEP 1000.
        send(OP_STEP, 32'd1000, "midrst_step");
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_outputs", 64'({reset_core, clk_core_en, busy, cmd_ready, done, bp_hit, cmd_err}),
              64'b1110000);
        check("midrst_cycles", cycle_count, 64'd0);
        @(negedge clk);
        release_and_measure("reboot");
        check("reboot_cycles", cycle_count, exp_cycles());

        repeat (5) @(negedge clk);
        drained("final_queue");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
